// File: rtl/maxpool_2x2_core_if.sv
// Pixel stream into the 2x2 max-pool core and the pooled stream coming out of it.
interface maxpool_2x2_core_if #(
  parameter int DATA_WIDTH = 16
);
  logic                         En;
  logic signed [DATA_WIDTH-1:0] Data_In;
  logic signed [DATA_WIDTH-1:0] Data_Out;
  logic                         Out_Valid;
  logic                         Frame_Done;

  modport master (
    output En,
    output Data_In,
    input  Data_Out,
    input  Out_Valid,
    input  Frame_Done
  );

  modport slave (
    input  En,
    input  Data_In,
    output Data_Out,
    output Out_Valid,
    output Frame_Done
  );
endinterface

// File: rtl/maxpool_2x2_core.sv
// 2x2 stride-2 signed max-pool over a raster pixel stream; 1-cycle latency, no backpressure (En only).
// Define MAXPOOL_RELU_EN to clamp negative pooled results to zero.
module maxpool_2x2_core #(
  parameter int IMG_SIZE   = 100,
  parameter int DATA_WIDTH = 16
) (
  input logic              Clk,
  input logic              Rst,
  maxpool_2x2_core_if.slave pix
);

  localparam int HALF = IMG_SIZE / 2;
  localparam int CW   = $clog2(IMG_SIZE);
  localparam int LBW  = (HALF > 1) ? $clog2(HALF) : 1;

  typedef logic signed [DATA_WIDTH-1:0] pix_t;

  logic [CW-1:0]  col;
  logic [CW-1:0]  row;
  pix_t           pair_q;
  pix_t           out_q;
  logic           vld_q;
  logic           done_q;
  pix_t           line_buf [HALF];

  logic           col_last;
  logic           row_last;
  logic           frame_last;
  logic           row_keep;
  logic           lb_write;
  logic           pool_emit;
  logic [LBW-1:0] lb_idx;
  pix_t           h_max;
  pix_t           v_max;
  pix_t           pooled;

  function automatic pix_t smax(input pix_t a, input pix_t b);
    return (a > b) ? a : b;
  endfunction

  assign col_last   = (col == CW'(IMG_SIZE - 1));
  assign row_last   = (row == CW'(IMG_SIZE - 1));
  assign frame_last = col_last && row_last;
  // The trailing row of an odd-sized image has no partner row; keep it out of the line buffer.
  assign row_keep   = !((IMG_SIZE % 2 == 1) && row_last);
  assign lb_idx     = LBW'(col >> 1);

  assign lb_write   = pix.En && col[0] && !row[0] && row_keep;
  assign pool_emit  = pix.En && col[0] && row[0];

  always_comb begin
    h_max = smax(pair_q, pix.Data_In);
    v_max = smax(h_max, line_buf[lb_idx]);
`ifdef MAXPOOL_RELU_EN
    pooled = v_max[DATA_WIDTH-1] ? '0 : v_max;
`else
    pooled = v_max;
`endif
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      col    <= '0;
      row    <= '0;
      pair_q <= '0;
      out_q  <= '0;
      vld_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      vld_q  <= 1'b0;
      done_q <= 1'b0;
      if (pix.En) begin
        if (!col[0]) begin
          pair_q <= pix.Data_In;
        end
        if (pool_emit) begin
          out_q <= pooled;
          vld_q <= 1'b1;
        end
        done_q <= frame_last;
        if (col_last) begin
          col <= '0;
          row <= row_last ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

  // No reset: each entry is rewritten on an even row before the odd row reads it.
  always_ff @(posedge Clk) begin
    if (!Rst && lb_write) begin
      line_buf[lb_idx] <= h_max;
    end
  end

  assign pix.Data_Out   = out_q;
  assign pix.Out_Valid  = vld_q;
  assign pix.Frame_Done = done_q;

endmodule
